// File: rtl/scp_ctrl_pkg.sv
// Shared control definitions for the SCP core sequencers: state encoding
// and default datapath widths.
package scp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    WAIT = 2'd2,
    LOAD = 2'd3
  } jseq_state_t;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_OPERAND_OFS = 1;
  localparam int DEF_MEM_TIMEOUT = 15;

endpackage

// File: rtl/jump_cond_eval.sv
// Combinational jump condition: unconditional jumps always take, conditional
// jumps test the register against zero in the direction selected by mode.
module jump_cond_eval
  import scp_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             cond_en,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  output logic             take
);

  logic good_s;

  // Condition decode
  always_comb begin
    good_s = 1'b0;
    if (mode) begin
      good_s = (a == {WIDTH{1'b0}});
    end else begin
      good_s = (a != {WIDTH{1'b0}});
    end
    take = !cond_en || good_s;
  end

endmodule

// File: rtl/jump_seq.sv
// Jump sequencer: evaluates the latched condition, fetches the target operand
// on a taken jump and issues a single PC write (or a timeout error pulse).
module jump_seq
  import scp_ctrl_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int OPERAND_OFS = DEF_OPERAND_OFS,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cond_en,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] pc,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [WIDTH-1:0] pc_next,
  output logic             busy,
  output logic             taken,
  output logic             err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [WIDTH-1:0] OFS_ADDR = WIDTH'(OPERAND_OFS);
  localparam logic [WIDTH-1:0] OFS_SKIP = WIDTH'(OPERAND_OFS + 1);

  jseq_state_t      state_r, state_nx;
  logic             cond_en_r, cond_en_nx;
  logic             mode_r, mode_nx;
  logic [WIDTH-1:0] a_r, a_nx;
  logic [WIDTH-1:0] pc_r, pc_nx;
  logic [WIDTH-1:0] target_r, target_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic             mem_req_r, mem_req_nx;
  logic [WIDTH-1:0] mem_addr_r, mem_addr_nx;
  logic             pc_we_r, pc_we_nx;
  logic [WIDTH-1:0] pc_next_r, pc_next_nx;
  logic             busy_r, busy_nx;
  logic             taken_r, taken_nx;
  logic             err_r, err_nx;
  logic             take_s;

  jump_cond_eval #(.WIDTH(WIDTH)) u_cond (
    .cond_en (cond_en_r),
    .mode    (mode_r),
    .a       (a_r),
    .take    (take_s)
  );

  // Next-state and next-output logic; pulses default low every cycle
  always_comb begin
    state_nx    = state_r;
    cond_en_nx  = cond_en_r;
    mode_nx     = mode_r;
    a_nx        = a_r;
    pc_nx       = pc_r;
    target_nx   = target_r;
    cnt_nx      = cnt_r;
    mem_req_nx  = mem_req_r;
    mem_addr_nx = mem_addr_r;
    pc_we_nx    = 1'b0;
    pc_next_nx  = pc_next_r;
    taken_nx    = taken_r;
    err_nx      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          cond_en_nx = cond_en;
          mode_nx    = mode;
          a_nx       = a;
          pc_nx      = pc;
          state_nx   = EVAL;
        end else begin
          state_nx   = IDLE;
        end
      end
      EVAL: begin
        taken_nx = take_s;
        if (take_s) begin
          mem_req_nx  = 1'b1;
          mem_addr_nx = pc_r + OFS_ADDR;
          cnt_nx      = {CNT_W{1'b0}};
          state_nx    = WAIT;
        end else begin
          pc_we_nx    = 1'b1;
          pc_next_nx  = pc_r + OFS_SKIP;
          state_nx    = IDLE;
        end
      end
      WAIT: begin
        // Ready on the last allowed cycle still wins over the timeout
        if (mem_ready) begin
          target_nx  = mem_data;
          mem_req_nx = 1'b0;
          state_nx   = LOAD;
        end else if (cnt_r == CNT_LAST) begin
          mem_req_nx = 1'b0;
          err_nx     = 1'b1;
          state_nx   = IDLE;
        end else begin
          cnt_nx     = cnt_r + CNT_W'(1);
        end
      end
      LOAD: begin
        pc_we_nx   = 1'b1;
        pc_next_nx = target_r;
        state_nx   = IDLE;
      end
      default: begin
        mem_req_nx = 1'b0;
        state_nx   = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // State, latches and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cond_en_r  <= 1'b0;
      mode_r     <= 1'b0;
      a_r        <= {WIDTH{1'b0}};
      pc_r       <= {WIDTH{1'b0}};
      target_r   <= {WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      mem_req_r  <= 1'b0;
      mem_addr_r <= {WIDTH{1'b0}};
      pc_we_r    <= 1'b0;
      pc_next_r  <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
      taken_r    <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nx;
      cond_en_r  <= cond_en_nx;
      mode_r     <= mode_nx;
      a_r        <= a_nx;
      pc_r       <= pc_nx;
      target_r   <= target_nx;
      cnt_r      <= cnt_nx;
      mem_req_r  <= mem_req_nx;
      mem_addr_r <= mem_addr_nx;
      pc_we_r    <= pc_we_nx;
      pc_next_r  <= pc_next_nx;
      busy_r     <= busy_nx;
      taken_r    <= taken_nx;
      err_r      <= err_nx;
    end
  end

  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;
  assign pc_we    = pc_we_r;
  assign pc_next  = pc_next_r;
  assign busy     = busy_r;
  assign taken    = taken_r;
  assign err      = err_r;

endmodule

// File: tb/tb_jump_seq.sv
// Scoreboard bench for jump_seq: each jump pushes its expected completion
// event (kind, cycle, pc_next, taken) and a negedge monitor pops and compares.
module tb_jump_seq;

  localparam int W   = 16;
  localparam int OFS = 1;
  localparam int T   = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, cond_en, mode, mem_ready;
  logic [W-1:0]  a, pc, mem_data;
  logic          mem_req, pc_we, busy, taken, err;
  logic [W-1:0]  mem_addr, pc_next;

  typedef struct {
    logic         is_err;
    logic [W-1:0] pcv;
    logic         tk;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  jump_seq #(.WIDTH(W), .OPERAND_OFS(OFS), .MEM_TIMEOUT(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cond_en   (cond_en),
    .mode      (mode),
    .a         (a),
    .pc        (pc),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .pc_we     (pc_we),
    .pc_next   (pc_next),
    .busy      (busy),
    .taken     (taken),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Completion monitor: every pc_we/err pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (pc_we || err)) begin
      if (sb.size() == 0) begin
        check_eq("spurious_pulse", {30'd0, pc_we, err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("evt_kind", {30'd0, pc_we, err}, {30'd0, !mon_e.is_err, mon_e.is_err});
        check_eq("evt_cycle", cyc, mon_e.cyc);
        if (!mon_e.is_err) check_eq("pc_next", {16'd0, pc_next}, {16'd0, mon_e.pcv});
        check_eq("taken", {31'd0, taken}, {31'd0, mon_e.tk});
      end
    end
  end

  // Drives one jump starting in the current cycle (called just after posedge)
  task automatic do_jump(input logic ce, input logic md, input logic [W-1:0] av,
                         input logic [W-1:0] pcv, input int d, input logic never,
                         input logic [W-1:0] data, input logic dup);
    logic  tk;
    int    k, end_i, last_wait;
    exp_t  e;
    tk        = !ce || (md ? (av == 16'd0) : (av != 16'd0));
    k         = cyc;
    end_i     = !tk ? 2 : (never ? 2 + T : 4 + d);
    last_wait = never ? 1 + T : 2 + d;
    e.is_err  = tk && never;
    e.pcv     = tk ? data : pcv + 16'(OFS + 1);
    e.tk      = tk;
    e.cyc     = k + end_i;
    sb.push_back(e);
    for (int i = 0; i <= end_i + 1; i++) begin
      start     = (i == 0) || (dup && i == 2);
      cond_en   = (i == 2 && dup) ? 1'b0 : ce;
      mode      = md;
      a         = (i == 2 && dup) ? 16'hFFFF : av;
      pc        = (i == 2 && dup) ? 16'hAAAA : pcv;
      mem_ready = (i == 1) || (tk && !never && i == 2 + d);
      mem_data  = (tk && !never && i == 2 + d) ? data : 16'hDEAD;
      @(negedge clk);
      check_eq("busy", {31'd0, busy}, {31'd0, (i >= 1 && i < end_i)});
      check_eq("mem_req", {31'd0, mem_req}, {31'd0, (tk && i >= 2 && i <= last_wait)});
      if (tk && i >= 2 && i <= last_wait)
        check_eq("mem_addr", {16'd0, mem_addr}, {16'd0, pcv + 16'(OFS)});
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {11'd0, mem_req, mem_addr, pc_we, busy, taken, err},
             32'd0);
    check_eq({tag, "_pc_next"}, {16'd0, pc_next}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cond_en = 1'b0; mode = 1'b0;
    a = '0; pc = '0; mem_data = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_jump(1'b0, 1'b0, 16'h0000, 16'h0010, 0, 1'b0, 16'h1234, 1'b0);
    do_jump(1'b1, 1'b0, 16'h0000, 16'h0020, 0, 1'b0, 16'h0000, 1'b0);
    do_jump(1'b1, 1'b1, 16'h0000, 16'hFFFF, 3, 1'b0, 16'h0100, 1'b0);
    do_jump(1'b0, 1'b0, 16'h0000, 16'h0300, 0, 1'b1, 16'h0000, 1'b0);
    do_jump(1'b0, 1'b0, 16'h0000, 16'h0400, T - 1, 1'b0, 16'h0ABC, 1'b0);
    do_jump(1'b1, 1'b0, 16'h0005, 16'h0500, 1, 1'b0, 16'h0555, 1'b1);
    do_jump(1'b1, 1'b1, 16'h0007, 16'h0600, 0, 1'b0, 16'h0000, 1'b0);
    do_jump(1'b1, 1'b0, 16'h0001, 16'h0700, 2, 1'b0, 16'h7777, 1'b0);
    do_jump(1'b1, 1'b1, 16'h0003, 16'hFFFF, 0, 1'b0, 16'h0000, 1'b0);
    for (int r = 0; r < 8; r++) begin
      do_jump(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'($urandom_range(0, 2)), 16'($urandom), $urandom_range(0, 4),
              1'b0, 16'($urandom), 1'b0);
    end

    // Reset while waiting for memory: everything clears, no late pc_we
    start = 1'b1; cond_en = 1'b0; a = 16'h0000; pc = 16'h0800;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_all_zero("post_reset_idle");

    repeat (5) @(posedge clk);
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
